// File: rtl/pll_lock_reset_seq_if.sv
// Sequencer-side bundle: raw PLL lock in, downstream reset/status out.
// PLL_LOCK_WATCHDOG_EN adds the pll_reset line back to the PLL.
interface pll_lock_reset_seq_if #(parameter int CNT_W = 8);
  logic             locked_async;
  logic             rst_out_n;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic [1:0]       state_dbg;
`ifdef PLL_LOCK_WATCHDOG_EN
  logic             pll_reset;
  modport master (output locked_async, input rst_out_n, ready, loss_count, state_dbg, pll_reset);
  modport slave  (input locked_async, output rst_out_n, ready, loss_count, state_dbg, pll_reset);
`else
  modport master (output locked_async, input rst_out_n, ready, loss_count, state_dbg);
  modport slave  (input locked_async, output rst_out_n, ready, loss_count, state_dbg);
`endif
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier: holds the CLKOUT domain in reset until lock is stable.
// Optional lock watchdog (pll_reset pulse) enabled by PLL_LOCK_WATCHDOG_EN.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 1024,
  parameter int MIN_RST_CYCLES = 16,
  parameter int CNT_W          = 8
`ifdef PLL_LOCK_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input logic                 CLK,
  input logic                 RST_N,
  pll_lock_reset_seq_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  MIN_LOAD  = 8'(MIN_RST_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   lock_s;
  logic [15:0]            hold_cnt, hold_nxt;
  logic [7:0]             min_cnt, min_nxt;
  logic [CNT_W-1:0]       loss_cnt, loss_nxt;
  logic                   rst_q, ready_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.locked_async};
  end

  assign lock_s = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      min_cnt  <= MIN_LOAD;
      loss_cnt <= '0;
      rst_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      min_cnt  <= min_nxt;
      loss_cnt <= loss_nxt;
      rst_q    <= (state_nxt == RUN);
      ready_q  <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    loss_nxt  = loss_cnt;
    min_nxt   = (min_cnt == 8'd0) ? 8'd0 : min_cnt - 8'd1;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABILIZE;
          hold_nxt  = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          hold_nxt  = '0;
          min_nxt   = MIN_LOAD;
        end else if (hold_cnt == HOLD_LAST) begin
          // hold satisfied: park here until the minimum reset width has elapsed
          if (min_cnt == 8'd0) state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = LOST;
          min_nxt   = MIN_LOAD;
          if (loss_cnt != '1) loss_nxt = loss_cnt + 1'b1;
        end
      end
      LOST: begin
        if (min_cnt == 8'd0) begin
          state_nxt = WAIT_LOCK;
          min_nxt   = MIN_LOAD;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign bus.rst_out_n  = rst_q;
  assign bus.ready      = ready_q;
  assign bus.loss_count = loss_cnt;
  assign bus.state_dbg  = state;

`ifdef PLL_LOCK_WATCHDOG_EN
  localparam int         TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic [2:0]      pulse_cnt;
  logic            pll_rst_q;

  // timeout counter is frozen while the 8-cycle pulse is out, then restarts from 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt    <= '0;
      pulse_cnt <= '0;
      pll_rst_q <= 1'b0;
    end else if (state != WAIT_LOCK) begin
      to_cnt    <= '0;
      pulse_cnt <= '0;
      pll_rst_q <= 1'b0;
    end else if (pll_rst_q) begin
      if (pulse_cnt == 3'd7) begin
        pll_rst_q <= 1'b0;
        pulse_cnt <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + 3'd1;
      end
    end else if (to_cnt == TO_LAST) begin
      pll_rst_q <= 1'b1;
      to_cnt    <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign bus.pll_reset = pll_rst_q;
`endif

endmodule
